// File: rtl/serial_parity_tx.sv
// serial_parity_tx: parallel-in, serial-out framer.
// Frame on tx: start bit (0), WIDTH data bits LSB first, optional even parity
// bit, stop bit (1). Every bit lasts CLKS_PER_BIT clock cycles.
// Optional feature: define SERIAL_PARITY_TX_PARITY_EN to add the even parity
// bit. In the default build there is no parity state and no parity register.
//
// Handshake: a word is taken on a rising edge where din_valid && din_ready.
// din_ready is high only in IDLE. din_valid is ignored in every other state,
// so din may change freely once a word has been taken.
module serial_parity_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam logic [7:0] CNT_MAX = 8'(CLKS_PER_BIT - 1);
  localparam logic [4:0] BIT_MAX = 5'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef SERIAL_PARITY_TX_PARITY_EN
    , PARITY = 3'd4
`endif
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [7:0]       cnt;       // cycle count inside the current bit period
  logic [4:0]       bit_idx;   // index of the data bit being sent
  logic [WIDTH-1:0] shreg;     // captured word; bit 0 is the bit on the line
  logic             bit_last;  // last cycle of the current bit period
  logic             accept;
`ifdef SERIAL_PARITY_TX_PARITY_EN
  logic             parity_q;
`endif

  assign bit_last = (cnt == CNT_MAX);
  assign accept   = din_valid && din_ready;

  // Next-state logic and the per-state outputs.
  always_comb begin
    state_next = state;
    tx         = 1'b1;
    busy       = (state != IDLE);
    din_ready  = (state == IDLE);
    case (state)
      IDLE: begin
        if (din_valid) state_next = START;
      end
      START: begin
        tx = 1'b0;
        if (bit_last) state_next = DATA;
      end
      DATA: begin
        tx = shreg[0];
        if (bit_last && (bit_idx == BIT_MAX)) begin
`ifdef SERIAL_PARITY_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef SERIAL_PARITY_TX_PARITY_EN
      PARITY: begin
        tx = parity_q;
        if (bit_last) state_next = STOP;
      end
`endif
      STOP: begin
        if (bit_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; reset drops any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Bit-period counter, data bit index and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else if (state == IDLE) begin
      cnt     <= '0;
      bit_idx <= '0;
      if (accept) shreg <= din;
    end else begin
      cnt <= bit_last ? 8'd0 : cnt + 8'd1;
      if ((state == DATA) && bit_last) begin
        shreg   <= shreg >> 1;
        bit_idx <= (bit_idx == BIT_MAX) ? 5'd0 : bit_idx + 5'd1;
      end
    end
  end

`ifdef SERIAL_PARITY_TX_PARITY_EN
  // Even parity is fixed at the accept edge so later din changes cannot leak in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      parity_q <= 1'b0;
    else if (accept) parity_q <= ^din;
  end
`endif

  // done is high for the first IDLE cycle after the last stop-bit cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done <= 1'b0;
    else        done <= (state == STOP) && bit_last;
  end

endmodule

// File: tb/tb_serial_parity_tx.sv
// tb_serial_parity_tx: directed, table-driven bench for serial_parity_tx
// (WIDTH=8, CLKS_PER_BIT=4). Honours SERIAL_PARITY_TX_PARITY_EN like the design.
module tb_serial_parity_tx;

  localparam int CPB = 4;
`ifdef SERIAL_PARITY_TX_PARITY_EN
  localparam int NBITS = 11;  // start + 8 data + parity + stop
`else
  localparam int NBITS = 10;  // start + 8 data + stop
`endif
  localparam int FRAME = NBITS * CPB;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       tx;
  logic       busy;
  logic       done;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic [7:0] din;
    logic       exp_par;  // hand-computed even parity
  } vec_t;

  vec_t vecs[6];

  serial_parity_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .tx        (tx),
    .busy      (busy),
    .done      (done)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare the packed {tx, busy, done, din_ready} against the expectation.
  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {tx,busy,done,rdy}=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Expected line level for cycle c of a frame carrying word d.
  function automatic logic exp_bit(input logic [7:0] d, input logic par, input int c);
    int idx;
    idx = c / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
`ifdef SERIAL_PARITY_TX_PARITY_EN
    if (idx == 9) return par;
`endif
    return 1'b1;
  endfunction

  // Called just after the accept edge. Checks every frame cycle, then the done
  // cycle. With disturb set, din_valid is raised with a different din mid-frame.
  task automatic check_frame(input string name, input logic [7:0] d, input logic par,
                             input bit disturb);
    logic [3:0] exp_q[$];
    for (int c = 0; c < FRAME; c++) exp_q.push_back({exp_bit(d, par, c), 1'b1, 1'b0, 1'b0});
    exp_q.push_back(4'b1011);  // first IDLE cycle: tx=1, done=1, ready=1
    for (int c = 0; c <= FRAME; c++) begin
      @(negedge clk);
      if (disturb && c == 6) begin din = ~d; din_valid = 1'b1; end
      if (disturb && c == 30) din_valid = 1'b0;
      check(name, {tx, busy, done, din_ready}, exp_q.pop_front());
    end
  endtask

  // Offer a word for one accept edge, then check its frame.
  task automatic send(input string name, input logic [7:0] d, input logic par, input bit disturb);
    @(negedge clk);
    din       = d;
    din_valid = 1'b1;
    @(posedge clk);
    #1 din_valid = 1'b0;
    check_frame(name, d, par, disturb);
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    din       = 8'h00;
    din_valid = 1'b0;
    rst_n     = 1'b0;

    vecs[0] = '{din: 8'hA5, exp_par: 1'b0};
    vecs[1] = '{din: 8'h01, exp_par: 1'b1};
    vecs[2] = '{din: 8'hFF, exp_par: 1'b0};
    vecs[3] = '{din: 8'h00, exp_par: 1'b0};
    vecs[4] = '{din: 8'h07, exp_par: 1'b1};
    vecs[5] = '{din: 8'h80, exp_par: 1'b1};

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_hold", {tx, busy, done, din_ready}, 4'b1001);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_release", {tx, busy, done, din_ready}, 4'b1001);

    // Table-driven frames; the first one also disturbs din mid-frame.
    for (int i = 0; i < 6; i++) begin
      send($sformatf("vec%0d_%h", i, vecs[i].din), vecs[i].din, vecs[i].exp_par, i == 0);
      @(negedge clk);
      check("idle_after_done", {tx, busy, done, din_ready}, 4'b1001);
    end

    // Back-to-back: din_valid held high, second accept on the done cycle.
    @(negedge clk);
    din       = 8'h3C;
    din_valid = 1'b1;
    @(posedge clk);
    #1 din = 8'hC3;
    check_frame("b2b_first_3c", 8'h3C, 1'b0, 1'b0);
    @(posedge clk);
    #1 din_valid = 1'b0;
    check_frame("b2b_second_c3", 8'hC3, 1'b0, 1'b0);

    // Reset during data bit 3: line idles at once, no done, next frame clean.
    @(negedge clk);
    din       = 8'hA5;
    din_valid = 1'b1;
    @(posedge clk);
    #1 din_valid = 1'b0;
    repeat (CPB + 3 * CPB + 2) @(negedge clk);
    check("pre_reset_bit3", {tx, busy, done, din_ready}, 4'b0100);  // A5 bit3 = 0
    rst_n = 1'b0;
    #1 check("mid_frame_reset", {tx, busy, done, din_ready}, 4'b1001);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < FRAME + 4; c++) begin
      @(negedge clk);
      if (done) check("no_done_after_reset", {tx, busy, done, din_ready}, 4'b1001);
    end
    check("idle_after_reset", {tx, busy, done, din_ready}, 4'b1001);
    send("after_reset_5a", 8'h5A, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
